// File: rtl/axi4_stream_pkg.sv
// Shared types for the AXI4-Stream packet generator.
//   pkt_gen_state_e    : generator FSM state encoding
//   axi4_stream_word_t : one stream beat, sized from the AXIS_* widths below.
//                        Use it where a fixed-width beat container is handy,
//                        e.g. in an external register slice.
package axi4_stream_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pkt_gen_state_e;

  localparam int AXIS_TDATA_W = 32;
  localparam int AXIS_TKEEP_W = AXIS_TDATA_W / 8;
  localparam int AXIS_TID_W   = 1;
  localparam int AXIS_TDEST_W = 1;
  localparam int AXIS_TUSER_W = 1;

  typedef struct packed {
    logic [AXIS_TDATA_W-1:0] tdata;
    logic [AXIS_TKEEP_W-1:0] tkeep;
    logic [AXIS_TKEEP_W-1:0] tstrb;
    logic                    tlast;
    logic [AXIS_TID_W-1:0]   tid;
    logic [AXIS_TDEST_W-1:0] tdest;
    logic [AXIS_TUSER_W-1:0] tuser;
  } axi4_stream_word_t;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle.
//   master modport: drives tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser,
//                   samples tready
//   slave modport : the reverse
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TKEEP_WIDTH-1:0] tstrb;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream packet generator: on an accepted start, emits pkt_len_i words
// of incrementing data (seed, seed+1, ...) with tuser[0] marking the first
// word and tlast marking the last one.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : start one packet (ignored while busy or when pkt_len_i==0)
//   pkt_len_i    : packet length in words
//   seed_i       : data value of word 0
//   tid_i/tdest_i: sideband for the packet, captured at start
//   busy_o       : packet in progress
//   done_o       : one-cycle pulse after the last word's handshake
//   pkt_o        : generated stream (master)
//
// state   | meaning
// ST_IDLE | waiting for a start with non-zero length
// ST_SEND | presenting words; leaves on the last word's handshake
module axi4_stream_pkt_gen
  import axi4_stream_pkg::*;
#(
  parameter int TDATA_WIDTH   = 32,
  parameter int TID_WIDTH     = 1,
  parameter int TDEST_WIDTH   = 1,
  parameter int TUSER_WIDTH   = 1,
  parameter int PKT_LEN_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [PKT_LEN_WIDTH-1:0] pkt_len_i,
  input  logic [TDATA_WIDTH-1:0]   seed_i,
  input  logic [TID_WIDTH-1:0]     tid_i,
  input  logic [TDEST_WIDTH-1:0]   tdest_i,
  output logic                     busy_o,
  output logic                     done_o,
  axi4_stream_if.master            pkt_o
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  pkt_gen_state_e state_q, state_d;

  // rem_q counts words still to follow the one currently presented, so
  // lengths up to 2^PKT_LEN_WIDTH-1 fit in a PKT_LEN_WIDTH-bit counter.
  logic [PKT_LEN_WIDTH-1:0] rem_q,   rem_d;
  logic [TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [TKEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
  logic [TID_WIDTH-1:0]     tid_q,   tid_d;
  logic [TDEST_WIDTH-1:0]   tdest_q, tdest_d;
  logic [TUSER_WIDTH-1:0]   tuser_q, tuser_d;
  logic                     tlast_q, tlast_d;
  logic                     done_q,  done_d;

  logic accept;
  logic handshake;

  assign accept    = (state_q == ST_IDLE) && start_i && (pkt_len_i != '0);
  assign handshake = (state_q == ST_SEND) && pkt_o.tready;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)              state_d = ST_SEND;
      ST_SEND: if (handshake && tlast_q) state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // outputs: tvalid/busy decode the state register directly, so nothing
  // on the stream depends combinationally on tready.
  always_comb begin
    busy_o       = (state_q == ST_SEND);
    done_o       = done_q;
    pkt_o.tvalid = (state_q == ST_SEND);
    pkt_o.tdata  = tdata_q;
    pkt_o.tkeep  = tkeep_q;
    pkt_o.tstrb  = tkeep_q;
    pkt_o.tlast  = tlast_q;
    pkt_o.tid    = tid_q;
    pkt_o.tdest  = tdest_q;
    pkt_o.tuser  = tuser_q;
  end

  // datapath next values; everything holds unless a start or handshake occurs
  always_comb begin
    rem_d   = rem_q;
    tdata_d = tdata_q;
    tkeep_d = tkeep_q;
    tid_d   = tid_q;
    tdest_d = tdest_q;
    tuser_d = tuser_q;
    tlast_d = tlast_q;
    done_d  = 1'b0;
    if (accept) begin
      rem_d   = pkt_len_i - PKT_LEN_WIDTH'(1);
      tdata_d = seed_i;
      tkeep_d = '1;
      tid_d   = tid_i;
      tdest_d = tdest_i;
      tuser_d = TUSER_WIDTH'(1);
      tlast_d = (pkt_len_i == PKT_LEN_WIDTH'(1));
    end else if (handshake) begin
      tuser_d = '0;
      if (tlast_q) begin
        tlast_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        rem_d   = rem_q - PKT_LEN_WIDTH'(1);
        tdata_d = tdata_q + TDATA_WIDTH'(1);
        tlast_d = (rem_q == PKT_LEN_WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q   <= '0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tid_q   <= '0;
      tdest_q <= '0;
      tuser_q <= '0;
      tlast_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      tdata_q <= tdata_d;
      tkeep_q <= tkeep_d;
      tid_q   <= tid_d;
      tdest_q <= tdest_d;
      tuser_q <= tuser_d;
      tlast_q <= tlast_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_axi4_stream_pkt_gen.sv
module tb_axi4_stream_pkt_gen;
  localparam int DW  = 32;
  localparam int IW  = 1;
  localparam int DSW = 1;
  localparam int UW  = 1;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] pkt_len;
  logic [DW-1:0] seed;
  logic [IW-1:0] tid;
  logic [DSW-1:0] tdest;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DSW),
                   .TUSER_WIDTH(UW)) pkt_if ();

  axi4_stream_pkt_gen #(
    .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DSW),
    .TUSER_WIDTH(UW), .PKT_LEN_WIDTH(LW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .pkt_len_i(pkt_len),
    .seed_i   (seed),
    .tid_i    (tid),
    .tdest_i  (tdest),
    .busy_o   (busy),
    .done_o   (done),
    .pkt_o    (pkt_if)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic           first;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rdy_random = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // reference model: a packet is simply seed+k for k = 0..len-1
  task automatic push_model(input logic [LW-1:0] len, input logic [DW-1:0] sd,
                            input logic [IW-1:0] id, input logic [DSW-1:0] dst);
    exp_t e;
    for (int k = 0; k < int'(len); k++) begin
      e.data  = sd + DW'(k);
      e.first = (k == 0);
      e.last  = (k == int'(len) - 1);
      e.id    = id;
      e.dest  = dst;
      exp_q.push_back(e);
    end
  endtask

  // tready driver
  initial begin
    pkt_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pkt_if.tready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor / scoreboard
  bit             prev_last = 1'b0;
  bit             stalled   = 1'b0;
  exp_t           got;
  logic [DW-1:0]  s_data;
  logic           s_last;
  logic [UW-1:0]  s_user;
  logic [IW-1:0]  s_id;
  logic [DSW-1:0] s_dest;

  always @(negedge clk) begin
    if (rst) begin
      prev_last = 1'b0;
      stalled   = 1'b0;
    end else begin
      chk("done_o", done, prev_last);
      if (prev_last) chk("busy_after_last", busy, 1'b0);
      if (stalled) begin
        chk("stall_tvalid", pkt_if.tvalid, 1'b1);
        chk("stall_tdata", pkt_if.tdata, s_data);
        chk("stall_tlast", pkt_if.tlast, s_last);
        chk("stall_tuser", pkt_if.tuser, s_user);
        chk("stall_tid", pkt_if.tid, s_id);
        chk("stall_tdest", pkt_if.tdest, s_dest);
      end
      prev_last = 1'b0;
      stalled   = 1'b0;
      if (pkt_if.tvalid) chk("busy_while_valid", busy, 1'b1);
      if (pkt_if.tvalid && pkt_if.tready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          got = exp_q.pop_front();
          chk("tdata", pkt_if.tdata, got.data);
          chk("tuser", pkt_if.tuser, {{(UW-1){1'b0}}, got.first});
          chk("tlast", pkt_if.tlast, got.last);
          chk("tid", pkt_if.tid, got.id);
          chk("tdest", pkt_if.tdest, got.dest);
          chk("tkeep", pkt_if.tkeep, 4'hF);
          chk("tstrb", pkt_if.tstrb, 4'hF);
          prev_last = got.last;
        end
      end else if (pkt_if.tvalid) begin
        stalled = 1'b1;
        s_data  = pkt_if.tdata;
        s_last  = pkt_if.tlast;
        s_user  = pkt_if.tuser;
        s_id    = pkt_if.tid;
        s_dest  = pkt_if.tdest;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) fail_now("idle_timeout");
  endtask

  // edges: clock edges from acceptance to the cycle where done_o is seen
  task automatic send_pkt(input logic [LW-1:0] len, input logic [DW-1:0] sd,
                          input logic [IW-1:0] id, input logic [DSW-1:0] dst,
                          output int edges);
    wait_idle();
    push_model(len, sd, id, dst);
    start = 1'b1; pkt_len = len; seed = sd; tid = id; tdest = dst;
    @(posedge clk);
    #1;
    edges = 1;
    start = 1'b0;
    pkt_len = LW'($urandom); seed = $urandom; tid = IW'($urandom); tdest = DSW'($urandom);
    if (len != '0) begin
      chk("tvalid_latency", pkt_if.tvalid, 1'b1);
      chk("busy_on_start", busy, 1'b1);
      while (done !== 1'b1 && edges < 5000) begin
        @(posedge clk);
        #1;
        edges++;
      end
      if (edges >= 5000) fail_now("done_timeout");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int edges;

  initial begin
    rst = 1'b1; start = 1'b0; pkt_len = '0; seed = '0; tid = '0; tdest = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", pkt_if.tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tdata", pkt_if.tdata, '0);
    chk("rst_tlast", pkt_if.tlast, 1'b0);
    chk("rst_tuser", pkt_if.tuser, '0);
    chk("rst_tkeep", pkt_if.tkeep, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // len 4, full throughput: words on consecutive cycles, done the next
    rdy_random = 1'b0;
    send_pkt(16'd4, 32'h10, 1'b1, 1'b0, edges);
    chk("len4_cycles", edges, 5);

    // len 3 under random backpressure
    rdy_random = 1'b1;
    send_pkt(16'd3, $urandom, 1'b0, 1'b1, edges);
    rdy_random = 1'b0;

    // data wrap-around
    send_pkt(16'd3, 32'hFFFF_FFFE, 1'b1, 1'b1, edges);
    chk("wrap_cycles", edges, 4);

    // zero length is ignored
    send_pkt(16'd0, 32'h55, 1'b0, 1'b0, edges);
    for (int i = 0; i < 3; i++) begin
      chk("len0_tvalid", pkt_if.tvalid, 1'b0);
      chk("len0_busy", busy, 1'b0);
      @(posedge clk);
      #1;
    end
    send_pkt(16'd1, 32'hABCD_0001, 1'b1, 1'b0, edges);
    chk("len1_cycles", edges, 2);

    // start held high: back-to-back packets, one-cycle gap, capture isolation
    wait_idle();
    push_model(16'd2, 32'h100, 1'b0, 1'b1);
    start = 1'b1; pkt_len = 16'd2; seed = 32'h100; tid = 1'b0; tdest = 1'b1;
    @(posedge clk);
    #1;
    chk("held_first_valid", pkt_if.tvalid, 1'b1);
    seed = 32'h200; tid = 1'b1; tdest = 1'b0;
    push_model(16'd2, 32'h200, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("held_gap_tvalid", pkt_if.tvalid, 1'b0);
    chk("held_gap_done", done, 1'b1);
    @(posedge clk);
    #1;
    chk("held_second_valid", pkt_if.tvalid, 1'b1);
    start = 1'b0;
    wait_idle();

    // reset while word 2 of 5 is presented
    push_model(16'd5, 32'h300, 1'b1, 1'b1);
    start = 1'b1; pkt_len = 16'd5; seed = 32'h300; tid = 1'b1; tdest = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_tdata", pkt_if.tdata, 32'h302);
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", pkt_if.tvalid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_tlast", pkt_if.tlast, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(16'd2, 32'h4000, 1'b0, 1'b0, edges);
    chk("post_rst_cycles", edges, 3);

    // randomized packets
    for (int p = 0; p < 12; p++) begin
      rdy_random = 1'($urandom_range(0, 1));
      send_pkt(LW'($urandom_range(1, 9)), $urandom, IW'($urandom), DSW'($urandom), edges);
    end
    rdy_random = 1'b0;

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_stream_pkt_gen.md
AXI4_STREAM_PKT_GEN -- requirements
Module: axi4_stream_pkt_gen

Interface
REQ-001 The block SHALL have parameter TDATA_WIDTH, default 32, meaning the tdata width in bits (a multiple of 8).
REQ-002 The block SHALL have parameter TID_WIDTH, default 1, meaning the tid width.
REQ-003 The block SHALL have parameter TDEST_WIDTH, default 1, meaning the tdest width.
REQ-004 The block SHALL have parameter TUSER_WIDTH, default 1, meaning the tuser width.
REQ-005 The block SHALL have parameter PKT_LEN_WIDTH, default 16, meaning the width of the packet length field in words.
REQ-006 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  - clk_i  input  1  single clock; all logic is on the rising edge.
  - rst_i  input  1  asynchronous, active-high reset.
  - start_i  input  1  request to start one packet.
  - pkt_len_i  input  PKT_LEN_WIDTH  packet length in words.
  - seed_i  input  TDATA_WIDTH  payload start value.
  - tid_i  input  TID_WIDTH  tid for the packet.
  - tdest_i  input  TDEST_WIDTH  tdest for the packet.
  - busy_o  output  1  a packet is in progress.
  - done_o  output  1  one-cycle pulse when a packet completes.
  - pkt_o  axi4_stream_if.master  -  generated stream.

Function
REQ-007 The block SHALL implement an FSM with two states:
  - IDLE -> SEND when start_i=1 and pkt_len_i!=0.
  - SEND -> IDLE on the handshake (tvalid&&tready) of the last word.
REQ-008 In IDLE, start_i with pkt_len_i=0 SHALL be ignored: no state change and no done_o.
REQ-009 On start acceptance, pkt_len_i, seed_i, tid_i and tdest_i SHALL be captured; later changes to these inputs SHALL NOT affect the packet in progress.
REQ-010 start_i SHALL be ignored while in SEND.
REQ-011 pkt_o.tvalid SHALL rise in the cycle after start acceptance (latency 1) and SHALL stay high through SEND until the last handshake.
REQ-012 Word k (k=0..N-1) SHALL carry tdata = seed + k, modulo 2^TDATA_WIDTH (wrap-around allowed).
REQ-013 Per-word sideband SHALL be:
  - tkeep and tstrb all ones.
  - tuser[0]=1 on word 0 only; all other tuser bits 0.
  - tlast=1 on word N-1 only.
  - tid and tdest equal to the captured values.
REQ-014 While tvalid=1 and tready=0, every pkt_o field SHALL hold stable; the word index SHALL advance only on a handshake.
REQ-015 All pkt_o outputs SHALL be driven from registers; no combinational path from pkt_o.tready to any pkt_o output.
REQ-016 The block SHALL sustain one word per cycle while tready=1.
REQ-017 The word counter SHALL be PKT_LEN_WIDTH wide and SHALL support N up to 2^PKT_LEN_WIDTH-1.
REQ-018 N=1 SHALL produce a single word with tuser[0]=1 and tlast=1.
REQ-019 busy_o SHALL be 1 exactly while in SEND, and 0 in the cycle after the last handshake.
REQ-020 done_o SHALL pulse for one cycle in the cycle after the last handshake.
REQ-021 A start_i asserted in the done_o cycle SHALL be accepted, giving a one-cycle gap between packets.

Reset
REQ-022 While rst_i=1, the block SHALL force: state=IDLE, tvalid=0, tlast=0, busy_o=0, done_o=0, counter=0, and tdata/tid/tdest/tuser/tkeep/tstrb=0.
REQ-023 Reset asserted mid-packet SHALL drop tvalid immediately (asynchronously); no partial tlast is emitted.
REQ-024 After reset deasserts, the next start_i SHALL begin a fresh packet from word 0.

Structure
REQ-025 The FSM state enum SHALL live in the shared axi4_stream_pkg package, alongside an axi4_stream_word_t-style packed struct parameterised by widths.
REQ-026 The block SHALL be a single module with no sub-module; a downstream register slice SHALL be optional and instantiated externally.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - len=4, seed=0x10, tready=1 -> tdata 0x10,0x11,0x12,0x13 on consecutive cycles; tuser[0] on word 0; tlast on word 3; done_o the next cycle.
  - len=3, tready toggled randomly -> every field stable while stalled; exactly 3 handshakes; order preserved.
  - seed=0xFFFFFFFE, len=3 -> tdata 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
  - len=0 start -> no tvalid, no done_o, busy_o stays 0; then len=1 -> single word with tuser[0]=1 and tlast=1.
  - start_i held high, len=2 -> packets back-to-back with a one-cycle gap; a start during SEND does not corrupt tid/tdest.
  - rst_i asserted during word 2 of 5 -> tvalid=0 and busy_o=0 at once; a new start gives word 0 = seed.
